exu_alu_arb: RTL and testbench

//   Shares the single combinational ALU between two issue requesters (req0, req1), for example
//   the two EXU dispatch slots. Each cycle a two-way round-robin arbiter grants at most one

---
 rtl/exu_alu_arb_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/exu_alu_arb.sv | 100 ++++++++++
 tb/tb_exu_alu_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exu_alu_arb_pkg.sv
// Shared widths and one-hot ALU op indices for the EXU ALU arbiter.
// Also provides a helper that builds a one-hot op vector from an op index.
package exu_alu_arb_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 12;
  localparam int ALU_RD_W   = 5;

  // Bit positions in the one-hot op vector, MSB first.
  localparam int ALU_OP_ADD   = 11;
  localparam int ALU_OP_SUB   = 10;
  localparam int ALU_OP_SLL   = 9;
  localparam int ALU_OP_SLT   = 8;
  localparam int ALU_OP_SLTU  = 7;
  localparam int ALU_OP_XOR   = 6;
  localparam int ALU_OP_SRL   = 5;
  localparam int ALU_OP_SRA   = 4;
  localparam int ALU_OP_OR    = 3;
  localparam int ALU_OP_AND   = 2;
  localparam int ALU_OP_LUI   = 1;
  localparam int ALU_OP_AUIPC = 0;

  function automatic logic [ALU_OP_W-1:0] alu_op_vec(input int idx);
    logic [ALU_OP_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Holds the last-grant pointer; on a tie the
// requester that did not win last time is granted.
module rr_arb2
  import exu_alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of latches.
    gnt = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer resets to 1 so req0 wins the first tie; it only moves on a grant.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst)
      last_gnt <= 1'b1;
    else if (|gnt)
      last_gnt <= gnt[1];
  end

endmodule

// File: rtl/exu_alu_arb.sv
// Shares one combinational ALU between two issue requesters and buffers the
// result in a one-entry writeback register drained through valid/ready.
module exu_alu_arb
  import exu_alu_arb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int RD_W   = ALU_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [RD_W-1:0]   req0_rd_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [RD_W-1:0]   req1_rd_i,

  output logic              alu_req_o,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [DATA_W-1:0] alu_op2_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [RD_W-1:0]   alu_rd_o,
  output logic              alu_int_o,
  input  logic [DATA_W-1:0] alu_result_i,

  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [RD_W-1:0]   wb_waddr_o,
  output logic              wb_we_o,
  output logic              wb_src_o
);

  logic       can_issue;
  logic [1:0] gnt;

  // A new result may enter only if the register is empty or draining this cycle.
  assign can_issue = !flush_i && (!wb_valid_o || wb_ready_i);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (can_issue),
    .valid ({req1_valid_i, req0_valid_i}),
    .gnt   (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign alu_req_o    = |gnt;
  assign alu_int_o    = flush_i;

  always_comb begin
    alu_op1_o = '0;
    alu_op2_o = '0;
    alu_op_o  = '0;
    alu_rd_o  = '0;
    if (gnt[0]) begin
      alu_op1_o = req0_op1_i;
      alu_op2_o = req0_op2_i;
      alu_op_o  = req0_op_i;
      alu_rd_o  = req0_rd_i;
    end else if (gnt[1]) begin
      alu_op1_o = req1_op1_i;
      alu_op2_o = req1_op2_i;
      alu_op_o  = req1_op_i;
      alu_rd_o  = req1_rd_i;
    end
  end

  // A grant always implies the slot is free, so load takes priority over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_waddr_o <= '0;
      wb_src_o   <= 1'b0;
    end else if (alu_req_o) begin
      wb_valid_o <= 1'b1;
      wb_data_o  <= alu_result_i;
      wb_waddr_o <= alu_rd_o;
      wb_src_o   <= gnt[1];
    end else if (flush_i || wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

  assign wb_we_o = wb_valid_o && (wb_waddr_o != '0);

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed bench for exu_alu_arb: a small ALU model feeds results back, and
// each scenario task compares outputs against hand-computed values.
module tb_exu_alu_arb;
  import exu_alu_arb_pkg::*;

  localparam int DW = ALU_DATA_W;
  localparam int OW = ALU_OP_W;
  localparam int RW = ALU_RD_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [DW-1:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [OW-1:0] r0_op, r1_op;
  logic [RW-1:0] r0_rd, r1_rd;
  logic          alu_req, alu_int;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [OW-1:0] alu_op;
  logic [RW-1:0] alu_rd;
  logic          wb_valid, wb_ready, wb_we, wb_src;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_waddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_alu_arb dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .req0_valid_i (r0_valid),
    .req0_ready_o (r0_ready),
    .req0_op1_i   (r0_op1),
    .req0_op2_i   (r0_op2),
    .req0_op_i    (r0_op),
    .req0_rd_i    (r0_rd),
    .req1_valid_i (r1_valid),
    .req1_ready_o (r1_ready),
    .req1_op1_i   (r1_op1),
    .req1_op2_i   (r1_op2),
    .req1_op_i    (r1_op),
    .req1_rd_i    (r1_rd),
    .alu_req_o    (alu_req),
    .alu_op1_o    (alu_op1),
    .alu_op2_o    (alu_op2),
    .alu_op_o     (alu_op),
    .alu_rd_o     (alu_rd),
    .alu_int_o    (alu_int),
    .alu_result_i (alu_result),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_data_o    (wb_data),
    .wb_waddr_o   (wb_waddr),
    .wb_we_o      (wb_we),
    .wb_src_o     (wb_src)
  );

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = '0;
    if      (alu_op[ALU_OP_ADD]) alu_result = alu_op1 + alu_op2;
    else if (alu_op[ALU_OP_SUB]) alu_result = alu_op1 - alu_op2;
    else if (alu_op[ALU_OP_XOR]) alu_result = alu_op1 ^ alu_op2;
    else if (alu_op[ALU_OP_OR])  alu_result = alu_op1 | alu_op2;
    else if (alu_op[ALU_OP_AND]) alu_result = alu_op1 & alu_op2;
    else if (alu_op[ALU_OP_SLL]) alu_result = alu_op1 << alu_op2[4:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op1 = '0; r0_op2 = '0; r0_op = '0; r0_rd = '0;
    r1_op1 = '0; r1_op2 = '0; r1_op = '0; r1_rd = '0;
    tick(); tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
    total++; if (wb_waddr !== '0) begin bad++; $display("FAIL reset_wb_waddr: got %0d want 0", wb_waddr); end
    total++; if (wb_src !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL reset_src_we: got %0b%0b want 00", wb_src, wb_we); end
    total++; if (alu_req !== 1'b0 || alu_op1 !== '0) begin bad++; $display("FAIL reset_alu_idle: got req=%0b op1=%0h want 0 0", alu_req, alu_op1); end
    rst = 1'b1;
  endtask

  task automatic test_single_req0();
    r0_op1 = 32'd5; r0_op2 = 32'd3; r0_op = alu_op_vec(ALU_OP_ADD); r0_rd = 5'd7;
    r0_valid = 1'b1; wb_ready = 1'b1;
    #1;
    total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %0b%0b want r1r0=01", r1_ready, r0_ready); end
    total++; if (alu_req !== 1'b1 || alu_op1 !== 32'd5 || alu_op2 !== 32'd3 || alu_rd !== 5'd7) begin bad++; $display("FAIL single_alu_mux: got req=%0b %0h %0h rd=%0d want 1 5 3 7", alu_req, alu_op1, alu_op2, alu_rd); end
    tick();
    r0_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'd8) begin bad++; $display("FAIL single_wb_data: got v=%0b %0h want 1 8", wb_valid, wb_data); end
    total++; if (wb_waddr !== 5'd7 || wb_we !== 1'b1 || wb_src !== 1'b0) begin bad++; $display("FAIL single_wb_ctl: got addr=%0d we=%0b src=%0b want 7 1 0", wb_waddr, wb_we, wb_src); end
  endtask

  task automatic test_rd_zero();
    r1_op1 = 32'hFF00; r1_op2 = 32'h0FF0; r1_op = alu_op_vec(ALU_OP_XOR); r1_rd = 5'd0;
    r1_valid = 1'b1;
    #1;
    total++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin bad++; $display("FAIL rd0_ready: got r1r0=%0b%0b want 10", r1_ready, r0_ready); end
    tick();
    r1_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hF0F0) begin bad++; $display("FAIL rd0_data: got v=%0b %0h want 1 f0f0", wb_valid, wb_data); end
    total++; if (wb_we !== 1'b0 || wb_src !== 1'b1 || wb_waddr !== 5'd0) begin bad++; $display("FAIL rd0_ctl: got we=%0b src=%0b addr=%0d want 0 1 0", wb_we, wb_src, wb_waddr); end
  endtask

  task automatic test_back_to_back();
    r0_op1 = 32'd1;  r0_op2 = 32'd1; r0_op = alu_op_vec(ALU_OP_ADD); r0_rd = 5'd1;
    r1_op1 = 32'd10; r1_op2 = 32'd3; r1_op = alu_op_vec(ALU_OP_SUB); r1_rd = 5'd2;
    r0_valid = 1'b1; r1_valid = 1'b1; wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (r0_ready !== (i % 2 == 0) || r1_ready !== (i % 2 == 1)) begin bad++; $display("FAIL b2b_grant[%0d]: got r1r0=%0b%0b want %0b%0b", i, r1_ready, r0_ready, (i % 2 == 1), (i % 2 == 0)); end
      tick();
      total++; if (wb_valid !== 1'b1 || wb_src !== (i % 2 == 1) || wb_data !== ((i % 2 == 0) ? 32'd2 : 32'd7)) begin bad++; $display("FAIL b2b_wb[%0d]: got v=%0b src=%0b data=%0h", i, wb_valid, wb_src, wb_data); end
    end
  endtask

  task automatic test_stall();
    wb_ready = 1'b0;
    #1;
    total++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || alu_req !== 1'b0) begin bad++; $display("FAIL stall_no_grant: got r1r0=%0b%0b req=%0b want 00 0", r1_ready, r0_ready, alu_req); end
    tick(); tick();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'd7 || wb_src !== 1'b1 || wb_waddr !== 5'd2) begin bad++; $display("FAIL stall_hold: got v=%0b %0h src=%0b addr=%0d want 1 7 1 2", wb_valid, wb_data, wb_src, wb_waddr); end
    wb_ready = 1'b1;
    #1;
    total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL stall_resume_grant: got r1r0=%0b%0b want 01", r1_ready, r0_ready); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_data !== 32'd2) begin bad++; $display("FAIL stall_resume_wb: got v=%0b src=%0b %0h want 1 0 2", wb_valid, wb_src, wb_data); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0; flush = 1'b1;
    #1;
    total++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || alu_req !== 1'b0 || alu_int !== 1'b1) begin bad++; $display("FAIL flush_block: got r1r0=%0b%0b req=%0b int=%0b want 00 0 1", r1_ready, r0_ready, alu_req, alu_int); end
    tick();
    flush = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got v=%0b want 0", wb_valid); end
    #1;
    total++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0 || alu_int !== 1'b0) begin bad++; $display("FAIL flush_pointer: got r1r0=%0b%0b int=%0b want 10 0", r1_ready, r0_ready, alu_int); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_data !== 32'd7) begin bad++; $display("FAIL flush_after: got v=%0b src=%0b %0h want 1 1 7", wb_valid, wb_src, wb_data); end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b1;
    #1;
    total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL rstmid_pre_grant: got r1r0=%0b%0b want 01", r1_ready, r0_ready); end
    tick();
    wb_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0 || wb_data !== '0 || wb_waddr !== '0) begin bad++; $display("FAIL rstmid_wb: got v=%0b %0h addr=%0d want 0 0 0", wb_valid, wb_data, wb_waddr); end
    total++; if (wb_src !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL rstmid_ctl: got src=%0b we=%0b want 0 0", wb_src, wb_we); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL rstmid_tie: got r1r0=%0b%0b want 01", r1_ready, r0_ready); end
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_data !== 32'd2) begin bad++; $display("FAIL rstmid_first: got v=%0b src=%0b %0h want 1 0 2", wb_valid, wb_src, wb_data); end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_rd_zero();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
